dspl_page_ctrl: RTL and testbench
=================================

// Module: dspl_page_ctrl
// PURPOSE
//   Two-page scheduler for the 8-digit Nexys A7 display driver; sits between the datapath and dspl_drv_NexysA7.
//   Latches two 16-bit data words (A, B) on update strobes.
//   Rotates the shown page on a timer or on a step pulse, and builds the d1..d8 digit words.
//   Digit word format (6 bits): {en, hex[3:0], dp}; en=1 lights the digit; dp is always 0.
// PARAMETERS
//   ROT_CYCLES    50_000_000  clock cycles per page in auto rotation (>=2)
//   FLASH_CYCLES  12_500_000  cycles d5..d8 are blanked after an update of the shown page (>=1)
//   LZB           1           1 = blank leading zero digits of the data field; 0 = show all four
// PORTS
//   clk      in   1   system clock, all state on rising edge
//   rst      in   1   asynchronous reset, active-high
//   prog     in   3   program code, shown on d1
//   modules  in   2   module code, shown on d2
//   data_a   in   16  page-A value, latched when valid_a=1
//   valid_a  in   1   single-cycle update strobe for data_a
//   data_b   in   16  page-B value, latched when valid_b=1
//   valid_b  in   1   single-cycle update strobe for data_b
//   next     in   1   single-cycle step request (already debounced/edge-detected)
//   hold     in   1   level; 1 freezes the rotation timer
//   page     out  1   current page (0=A, 1=B)
//   d1..d8   out  6   digit words to the display driver, all registered
// BEHAVIOUR
//   Reset (async, rst=1):
//     - page=0; reg_a=reg_b=0; rot_cnt=0; flash_cnt=0; d1..d8=6'b0 (all blank).
//   Data latch:
//     - valid_x=1 loads reg_x <= data_x at the clock edge.
//     - Both strobes in one cycle load both registers.
//   FSM states: SHOW_A (page=0), SHOW_B (page=1). Advance = toggle the state.
//     - Advance on next=1, or on rot_cnt==ROT_CYCLES-1 with hold=0.
//     - next and timer expiry in the same cycle advance ONCE.
//     - Any advance sets rot_cnt <= 0.
//     - hold=1: rot_cnt frozen, timer cannot advance; next still advances.
//     - Otherwise rot_cnt increments by 1; width $clog2(ROT_CYCLES).
//   Flash:
//     - A valid strobe for the currently shown page (sampled before any advance that cycle) sets flash_cnt <= FLASH_CYCLES.
//     - flash_cnt>0 decrements by 1 per cycle.
//     - A re-strobe while flashing reloads flash_cnt to FLASH_CYCLES.
//     - Any advance clears flash_cnt to 0. Advance wins over a same-cycle strobe, so no flash occurs.
//   Digit build (registered; 1-cycle latency from state/regs/inputs):
//     - d1={1,1'b0,prog,0}; d2={1,2'b0,modules,0}; d3={1,3'b0,page,0}; d4=6'b0.
//     - v = page ? reg_b : reg_a.
//     - d5..d8 = {1,v[15:12],0}..{1,v[3:0],0}.
//     - LZB=1: d5 blank if v[15:12]==0; d6 blank if v[15:8]==0; d7 blank if v[15:4]==0; d8 always lit.
//     - flash_cnt>0: d5..d8 = 6'b0 regardless of LZB.
//     - Blank digit = 6'b0.
//   Reset mid-operation:
//     - Immediate return to reset values; pending flash and timer progress are discarded.
// TESTING (ROT_CYCLES=8, FLASH_CYCLES=4, LZB=1)
//   1 Reset, no stimulus -> d1..d8=0; first edge after release gives d1={1,0,prog,0}, page=0, d8=6'b100000.
//   2 valid_b=1 data_b=16'h00A5 while page=0, hold=0 -> no flash; page=1 after 8 cycles;
//     next cycle d5=d6=0, d7={1,4'hA,0}, d8={1,4'h5,0}.
//   3 valid_a=1 data_a=16'h1234 while page=0 -> d5..d8=0 for 4 cycles, then 1,2,3,4 lit.
//   4 hold=1 for 20 cycles -> page constant; next pulse -> page toggles, rot_cnt=0; release hold -> next toggle 8 cycles later.
//   5 next=1 in the same cycle rot_cnt==7 -> single toggle; valid of shown page in the same cycle -> flash_cnt stays 0.
//   6 rst=1 asynchronously mid-flash, rot_cnt=5 -> outputs 0 without a clock edge; after release, page=0 and data regs=0.

Source files
------------

// File: rtl/dspl_page_ctrl.sv
// Two-page display scheduler: latches A/B data words, rotates the shown page on a
// timer or a step pulse, and builds the registered d1..d8 digit words for the driver.
module dspl_page_ctrl #(
    parameter int unsigned ROT_CYCLES   = 50_000_000,
    parameter int unsigned FLASH_CYCLES = 12_500_000,
    parameter bit          LZB          = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  prog,
    input  logic [1:0]  modules,
    input  logic [15:0] data_a,
    input  logic        valid_a,
    input  logic [15:0] data_b,
    input  logic        valid_b,
    input  logic        next,
    input  logic        hold,
    output logic        page,
    output logic [5:0]  d1,
    output logic [5:0]  d2,
    output logic [5:0]  d3,
    output logic [5:0]  d4,
    output logic [5:0]  d5,
    output logic [5:0]  d6,
    output logic [5:0]  d7,
    output logic [5:0]  d8
);

    localparam int ROT_W = $clog2(ROT_CYCLES);
    localparam int FL_W  = $clog2(FLASH_CYCLES + 1);
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_CYCLES - 1);
    localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'(FLASH_CYCLES);

    typedef enum logic {
        SHOW_A = 1'b0,
        SHOW_B = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_advance;
    logic             w_shown_vld;
    logic [ROT_W-1:0] r_rot_cnt;
    logic [FL_W-1:0]  r_flash_cnt;
    logic [15:0]      r_reg_a;
    logic [15:0]      r_reg_b;
    logic [15:0]      w_v;
    logic [5:0]       w_d5, w_d6, w_d7, w_d8;
    logic [5:0]       r_d1, r_d2, r_d3, r_d4, r_d5, r_d6, r_d7, r_d8;

    function automatic logic [5:0] lit_digit(input logic [3:0] h);
        return {1'b1, h, 1'b0};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SHOW_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Step request and timer expiry collapse into a single toggle.
    always_comb begin
        w_advance   = 1'b0;
        w_state_nxt = r_state;
        w_shown_vld = valid_a;
        if (next || (!hold && (r_rot_cnt == ROT_LAST))) begin
            w_advance = 1'b1;
        end
        case (r_state)
            SHOW_A: begin
                w_shown_vld = valid_a;
                if (w_advance) w_state_nxt = SHOW_B;
            end
            SHOW_B: begin
                w_shown_vld = valid_b;
                if (w_advance) w_state_nxt = SHOW_A;
            end
            default: w_state_nxt = SHOW_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rot_cnt   <= '0;
            r_flash_cnt <= '0;
            r_reg_a     <= '0;
            r_reg_b     <= '0;
        end else begin
            if (valid_a) r_reg_a <= data_a;
            if (valid_b) r_reg_b <= data_b;

            if (w_advance) begin
                r_rot_cnt <= '0;
            end else if (!hold) begin
                r_rot_cnt <= r_rot_cnt + 1'b1;
            end

            // A page change discards any flash, even one requested this same cycle.
            if (w_advance) begin
                r_flash_cnt <= '0;
            end else if (w_shown_vld) begin
                r_flash_cnt <= FL_LOAD;
            end else if (r_flash_cnt != '0) begin
                r_flash_cnt <= r_flash_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_v  = (r_state == SHOW_B) ? r_reg_b : r_reg_a;
        w_d5 = lit_digit(w_v[15:12]);
        w_d6 = lit_digit(w_v[11:8]);
        w_d7 = lit_digit(w_v[7:4]);
        w_d8 = lit_digit(w_v[3:0]);
        if (LZB) begin
            if (w_v[15:12] == 4'h0) w_d5 = 6'b0;
            if (w_v[15:8]  == 8'h0) w_d6 = 6'b0;
            if (w_v[15:4]  == 12'h0) w_d7 = 6'b0;
        end
        if (r_flash_cnt != '0) begin
            w_d5 = 6'b0;
            w_d6 = 6'b0;
            w_d7 = 6'b0;
            w_d8 = 6'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d1 <= 6'b0;
            r_d2 <= 6'b0;
            r_d3 <= 6'b0;
            r_d4 <= 6'b0;
            r_d5 <= 6'b0;
            r_d6 <= 6'b0;
            r_d7 <= 6'b0;
            r_d8 <= 6'b0;
        end else begin
            r_d1 <= {1'b1, 1'b0, prog, 1'b0};
            r_d2 <= {1'b1, 2'b0, modules, 1'b0};
            r_d3 <= {1'b1, 3'b0, (r_state == SHOW_B), 1'b0};
            r_d4 <= 6'b0;
            r_d5 <= w_d5;
            r_d6 <= w_d6;
            r_d7 <= w_d7;
            r_d8 <= w_d8;
        end
    end

    assign page = (r_state == SHOW_B);
    assign d1   = r_d1;
    assign d2   = r_d2;
    assign d3   = r_d3;
    assign d4   = r_d4;
    assign d5   = r_d5;
    assign d6   = r_d6;
    assign d7   = r_d7;
    assign d8   = r_d8;

endmodule

// File: tb/tb_dspl_page_ctrl.sv
// Scoreboard bench for dspl_page_ctrl with ROT_CYCLES=8, FLASH_CYCLES=4, LZB=1.
module tb_dspl_page_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  prog;
    logic [1:0]  modules;
    logic [15:0] data_a, data_b;
    logic        valid_a, valid_b, next, hold;
    logic        page;
    logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;

    dspl_page_ctrl #(
        .ROT_CYCLES   (8),
        .FLASH_CYCLES (4),
        .LZB          (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .prog    (prog),
        .modules (modules),
        .data_a  (data_a),
        .valid_a (valid_a),
        .data_b  (data_b),
        .valid_b (valid_b),
        .next    (next),
        .hold    (hold),
        .page    (page),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .d4      (d4),
        .d5      (d5),
        .d6      (d6),
        .d7      (d7),
        .d8      (d8)
    );

    always #5 clk = ~clk;

    // prog=3'b101 -> d1=6'b101010; modules=2'b10 -> d2=6'b100100
    localparam logic [5:0] D1_EXP = 6'h2A;
    localparam logic [5:0] D2_EXP = 6'h24;

    typedef struct {
        int          cyc;
        string       name;
        logic [48:0] vec;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_push(input int k, input string nm, input logic pg, input logic dpg,
                           input logic [5:0] e5, input logic [5:0] e6,
                           input logic [5:0] e7, input logic [5:0] e8);
        exp_t e;
        e.cyc  = cyc + k;
        e.name = nm;
        e.vec  = {pg, D1_EXP, D2_EXP, (dpg ? 6'h22 : 6'h20), 6'h00, e5, e6, e7, e8};
        sb.push_back(e);
    endtask

    task automatic sb_push_zero(input int k, input string nm);
        exp_t e;
        e.cyc  = cyc + k;
        e.name = nm;
        e.vec  = '0;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        logic [48:0] got;
        exp_t        e;
        got = {page, d1, d2, d3, d4, d5, d6, d7, d8};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else if (got !== e.vec) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got %h required %h", e.name, cyc, got, e.vec);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; prog = 3'b101; modules = 2'b10;
        data_a = '0; data_b = '0; valid_a = 0; valid_b = 0; next = 0; hold = 0;
        step(3);
        // Reset view, then first edge after release (v=0 -> only d8 lit)
        sb_push_zero(0, "reset_hold");
        sb_push(1, "first_edge", 0, 0, 6'h00, 6'h00, 6'h00, 6'h20);
        rst = 1'b0;
        step(1);
        // B update while A shown: no flash, timer flips to B after 8 edges
        sb_push(6, "rot_before", 0, 0, 6'h00, 6'h00, 6'h00, 6'h20);
        sb_push(7, "rot_toggle", 1, 0, 6'h00, 6'h00, 6'h00, 6'h20);
        sb_push(8, "b_00A5_lzb", 1, 1, 6'h00, 6'h00, 6'h34, 6'h2A);
        valid_b = 1; data_b = 16'h00A5;
        step(1);
        valid_b = 0;
        step(7);
        // Step back to A, then flash on A update
        sb_push(1, "next_to_a", 0, 1, 6'h00, 6'h00, 6'h34, 6'h2A);
        sb_push(2, "a_pre_flash", 0, 0, 6'h00, 6'h00, 6'h00, 6'h20);
        sb_push(3, "flash_first", 0, 0, 6'h00, 6'h00, 6'h00, 6'h00);
        sb_push(6, "flash_last", 0, 0, 6'h00, 6'h00, 6'h00, 6'h00);
        sb_push(7, "a_1234_lit", 0, 0, 6'h22, 6'h24, 6'h26, 6'h28);
        next = 1;
        step(1);
        next = 0; valid_a = 1; data_a = 16'h1234;
        step(1);
        valid_a = 0;
        step(5);
        // Hold freezes timer; next still steps; release gives a full 8-cycle period
        sb_push(11, "hold_mid", 0, 0, 6'h22, 6'h24, 6'h26, 6'h28);
        sb_push(20, "hold_end", 0, 0, 6'h22, 6'h24, 6'h26, 6'h28);
        sb_push(21, "hold_next", 1, 0, 6'h22, 6'h24, 6'h26, 6'h28);
        sb_push(22, "hold_b_view", 1, 1, 6'h00, 6'h00, 6'h34, 6'h2A);
        sb_push(29, "release_before", 1, 1, 6'h00, 6'h00, 6'h34, 6'h2A);
        sb_push(30, "release_toggle", 0, 1, 6'h00, 6'h00, 6'h34, 6'h2A);
        hold = 1;
        step(20);
        next = 1;
        step(1);
        next = 0;
        step(1);
        hold = 0;
        step(8);
        // next + expiry + shown-page strobe in one cycle: single toggle, no flash
        sb_push(7, "coinc_before", 0, 0, 6'h22, 6'h24, 6'h26, 6'h28);
        sb_push(8, "coinc_toggle", 1, 0, 6'h22, 6'h24, 6'h26, 6'h28);
        sb_push(9, "coinc_noflash", 1, 1, 6'h00, 6'h00, 6'h34, 6'h2A);
        sb_push(15, "coinc_period", 1, 1, 6'h00, 6'h00, 6'h34, 6'h2A);
        sb_push(16, "coinc_back_a", 0, 1, 6'h00, 6'h00, 6'h34, 6'h2A);
        sb_push(17, "a_0BCD_lzb", 0, 0, 6'h00, 6'h36, 6'h38, 6'h3A);
        step(7);
        next = 1; valid_a = 1; data_a = 16'h0BCD;
        step(1);
        next = 0; valid_a = 0;
        step(11);
        // Async reset mid-flash with rot_cnt=5
        sb_push_zero(2, "async_rst");
        sb_push_zero(4, "rst_held");
        sb_push(5, "post_rst", 0, 0, 6'h00, 6'h00, 6'h00, 6'h20);
        sb_push(11, "post_rst_before", 0, 0, 6'h00, 6'h00, 6'h00, 6'h20);
        sb_push(12, "post_rst_toggle", 1, 0, 6'h00, 6'h00, 6'h00, 6'h20);
        sb_push(13, "post_rst_b_zero", 1, 1, 6'h00, 6'h00, 6'h00, 6'h20);
        valid_a = 1; data_a = 16'hF00F;
        step(1);
        valid_a = 0;
        step(1);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(10);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
